// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: one-hot FSM shifting a parallel word out as
// start(1), data LSB first, optional parity, stop(0) on an idle-low line.
module fsm_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic                baud_tc;

  assign baud_tc = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    if (state_q != IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + BAUD_W'(1);
    end
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (tx_valid) begin
          shreg_d  = tx_data;
          parity_d = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
      end
      DATA: begin
        if (baud_tc) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tc) state_d = STOP;
      end
      STOP: begin
        if (baud_tc) state_d = IDLE;
      end
      default: begin
        // Corrupted (non-one-hot) state recovers straight to IDLE.
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  always_comb begin
    case (state_q)
      IDLE:    tx_out = 1'b0;
      START:   tx_out = 1'b1;
      DATA:    tx_out = shreg_q[0];
      PARITY:  tx_out = parity_q;
      STOP:    tx_out = 1'b0;
      default: tx_out = 1'b0;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = (state_q == STOP) && baud_tc;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: four parameterisations driven with directed and
// random words, line checked cycle by cycle against an expected bit list.
module tb_fsm_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a [4];
  logic [3:0] valid_v;
  logic [3:0] out_v, ready_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;
  bit exp_q [$];

  always #5 clk = ~clk;

  // 0: defaults, 1: odd parity, 2: no parity, 3: one clk per bit, no parity
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
    .clk(clk), .reset(reset), .tx_data(data_a[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_out(out_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .tx_data(data_a[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_out(out_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .reset(reset), .tx_data(data_a[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_out(out_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_c1 (
    .clk(clk), .reset(reset), .tx_data(data_a[3]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx_out(out_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  function automatic int cpb_of(input int idx);
    return (idx == 3) ? 1 : 4;
  endfunction
  function automatic bit pen_of(input int idx);
    return (idx == 0 || idx == 1);
  endfunction
  function automatic bit odd_of(input int idx);
    return (idx == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for every cycle of a frame, from the frame rules.
  task automatic build_exp(input int idx, input logic [7:0] d);
    bit bits [$];
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen_of(idx)) bits.push_back(bit'(($countones(d) % 2) == 1) ^ odd_of(idx));
    bits.push_back(1'b0);
    exp_q.delete();
    foreach (bits[i])
      for (int c = 0; c < cpb_of(idx); c++) exp_q.push_back(bits[i]);
  endtask

  task automatic idle_check(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_out", 32'(out_v[idx]), 32'd0);
      chk("idle_ready", 32'(ready_v[idx]), 32'd1);
      chk("idle_done", 32'(done_v[idx]), 32'd0);
      @(negedge clk);
    end
  endtask

  // Called at a negedge while idx is idle; returns at the negedge of the
  // cycle right after the frame ends (first IDLE cycle, not yet checked).
  task automatic run_frame(input int idx, input logic [7:0] d, input bit keep,
                           input logic [7:0] nd, input int inj);
    int len;
    chk("accept_ready", 32'(ready_v[idx]), 32'd1);
    valid_v[idx] = 1'b1;
    data_a[idx]  = d;
    build_exp(idx, d);
    len = exp_q.size();
    @(negedge clk);
    for (int k = 0; k < len; k++) begin
      chk("frame_out", 32'(out_v[idx]), 32'(exp_q[k]));
      chk("frame_ready", 32'(ready_v[idx]), 32'd0);
      chk("frame_busy", 32'(busy_v[idx]), 32'd1);
      chk("frame_done", 32'(done_v[idx]), (k == len - 1) ? 32'd1 : 32'd0);
      if (k == 0) begin
        if (keep) data_a[idx] = nd;
        else valid_v[idx] = 1'b0;
      end
      if (inj > 0 && k == inj) begin
        valid_v[idx] = 1'b1;
        data_a[idx]  = 8'hFF;
      end
      if (inj > 0 && k == inj + 1) begin
        valid_v[idx] = 1'b0;
        data_a[idx]  = d;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int ri;
    reset   = 1'b1;
    valid_v = 4'hF;
    for (int i = 0; i < 4; i++) data_a[i] = 8'hA5;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_out", 32'(out_v[i]), 32'd0);
      chk("rst_ready", 32'(ready_v[i]), 32'd1);
      chk("rst_busy", 32'(busy_v[i]), 32'd0);
      chk("rst_done", 32'(done_v[i]), 32'd0);
    end
    reset   = 1'b0;
    valid_v = 4'h0;
    @(negedge clk);
    idle_check(0, 2);

    // Default frame 0xA5 with a busy-time 0xFF pulse that must be ignored.
    run_frame(0, 8'hA5, 1'b0, 8'h00, 10);
    idle_check(0, 3);

    // Parity polarity and no-parity frame length.
    run_frame(0, 8'h01, 1'b0, 8'h00, 0);
    idle_check(0, 1);
    run_frame(1, 8'h01, 1'b0, 8'h00, 0);
    idle_check(1, 1);
    run_frame(2, 8'h01, 1'b0, 8'h00, 0);
    idle_check(2, 1);

    // Back-to-back: valid held high across both words.
    run_frame(0, 8'h3C, 1'b1, 8'hC3, 0);
    run_frame(0, 8'hC3, 1'b0, 8'h00, 0);
    idle_check(0, 2);

    // Reset asserted during DATA bit 3 aborts immediately.
    valid_v[0] = 1'b1;
    data_a[0]  = 8'hA5;
    build_exp(0, 8'hA5);
    @(negedge clk);
    valid_v[0] = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk("pre_abort_out", 32'(out_v[0]), 32'(exp_q[k]));
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_out", 32'(out_v[0]), 32'd0);
    chk("abort_ready", 32'(ready_v[0]), 32'd1);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(0, 1);
    run_frame(0, 8'h5A, 1'b0, 8'h00, 0);
    idle_check(0, 1);

    // One clock per bit.
    run_frame(3, 8'h80, 1'b0, 8'h00, 0);
    idle_check(3, 2);

    // Random words on random configurations.
    for (int r = 0; r < 8; r++) begin
      ri = int'($urandom_range(0, 3));
      rd = 8'($urandom);
      idle_check(ri, int'($urandom_range(0, 3)));
      run_frame(ri, rd, 1'b0, 8'h00, 0);
    end
    idle_check(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
